// File: rtl/bcd_counter_9675_pkg.sv
// Shared definitions for the decimal event counter.
//   BCD_W / bcd_digit_t : one packed BCD digit
//   NUM_DIGITS          : digits in the displayed count
//   DEF_MAX_*           : default terminal count 9675
//   bcd_inc             : single-digit BCD increment with carry out
package counter_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam int unsigned DEF_MAX_THOU = 9;
  localparam int unsigned DEF_MAX_HUND = 6;
  localparam int unsigned DEF_MAX_TENS = 7;
  localparam int unsigned DEF_MAX_ONES = 5;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_inc_t;

  // 9 (or any out-of-range code) rolls to 0 with a carry so a digit can never
  // leave the 0..9 range.
  function automatic bcd_inc_t bcd_inc(input bcd_digit_t d);
    bcd_inc_t r;
    if (d >= bcd_digit_t'(9)) begin
      r.carry = 1'b1;
      r.digit = '0;
    end else begin
      r.carry = 1'b0;
      r.digit = d + bcd_digit_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronises an asynchronous level into the fast_clock domain and flags its
// rising edges.
//   fast_clock : sampling clock
//   rst        : asynchronous active-high reset; all flops reset to 1
//   async_in   : asynchronous input level
//   rise       : high for one cycle after a synchronised 0->1 transition
//                (combinational from the internal flops)
module sync_rise_detect
  import counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic fast_clock,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_rise_detect: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history_q;

  // Resetting to 1 means a level that is already high when reset releases is
  // treated as old history rather than a fresh edge.
  always_ff @(posedge fast_clock or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      history_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
      history_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~history_q;

endmodule

// File: rtl/bcd_counter_9675.sv
// Decimal event counter driven by the divided slow_clock.
// Counts 0000..terminal in packed BCD and wraps to 0000.
//   fast_clock : system clock, all state on its rising edge
//   rst        : asynchronous active-high reset
//   slow_clock : divided clock, sampled as asynchronous data
//   count_en   : allow ticks to advance the count
//   clear      : synchronous clear to 0000 (beats increment)
//   bcd_count  : [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
//   tick       : one-cycle pulse per slow_clock rising edge
//   wrap       : one-cycle pulse when the count goes terminal -> 0000
module bcd_counter_9675
  import counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_THOU    = DEF_MAX_THOU,
  parameter int unsigned MAX_HUND    = DEF_MAX_HUND,
  parameter int unsigned MAX_TENS    = DEF_MAX_TENS,
  parameter int unsigned MAX_ONES    = DEF_MAX_ONES
) (
  input  logic        fast_clock,
  input  logic        rst,
  input  logic        slow_clock,
  input  logic        count_en,
  input  logic        clear,
  output logic [15:0] bcd_count,
  output logic        tick,
  output logic        wrap
);

  if (MAX_THOU > 9 || MAX_HUND > 9 || MAX_TENS > 9 || MAX_ONES > 9) begin : g_bad_max
    $error("bcd_counter_9675: each MAX_* digit must be in 0..9");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("bcd_counter_9675: SYNC_STAGES must be at least 2");
  end

  localparam bcd_digit_t TERM_THOU = bcd_digit_t'(MAX_THOU);
  localparam bcd_digit_t TERM_HUND = bcd_digit_t'(MAX_HUND);
  localparam bcd_digit_t TERM_TENS = bcd_digit_t'(MAX_TENS);
  localparam bcd_digit_t TERM_ONES = bcd_digit_t'(MAX_ONES);
  localparam logic [NUM_DIGITS-1:0][BCD_W-1:0] TERMINAL =
    {TERM_THOU, TERM_HUND, TERM_TENS, TERM_ONES};

  logic                              rise;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] count_q;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] count_inc;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .fast_clock(fast_clock),
    .rst       (rst),
    .async_in  (slow_clock),
    .rise      (rise)
  );

  // Ripple increment: each digit steps only when every lower digit rolled over.
  always_comb begin
    logic     carry;
    bcd_inc_t step;
    count_inc = count_q;
    carry     = 1'b1;
    step      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        step         = bcd_inc(count_q[i]);
        count_inc[i] = step.digit;
        carry        = step.carry;
      end
    end
  end

  always_ff @(posedge fast_clock or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      tick <= rise;
      wrap <= 1'b0;
      if (clear) begin
        count_q <= '0;
      end else if (rise && count_en) begin
        if (count_q == TERMINAL) begin
          count_q <= '0;
          wrap    <= 1'b1;
        end else begin
          count_q <= count_inc;
        end
      end
    end
  end

  assign bcd_count = count_q;

endmodule
